// File: rtl/key_press_conditioner_pkg.sv
// Shared constants, state type and output payload for the tug-of-war key front end.
package key_press_conditioner_pkg;

   localparam logic        KEY_ACTIVE       = 1'b0;
   localparam int unsigned DEFAULT_DEBOUNCE = 4;
   localparam int unsigned SYNC_STAGES      = 2;

   typedef enum logic {
      KEY_RELEASED = 1'b0,
      KEY_PRESSED  = 1'b1
   } key_st_e;

   typedef struct packed {
      logic tie;
      logic right;
      logic left;
   } press_out_t;

   // Same-edge presses collapse into a tie; en gates all three.
   function automatic press_out_t arbitrate(input logic en,
                                            input logic press_l,
                                            input logic press_r);
      press_out_t o;
      o.left  = en & press_l & ~press_r;
      o.right = en & press_r & ~press_l;
      o.tie   = en & press_l &  press_r;
      return o;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: two-flop synchroniser, consecutive-sample debounce filter and
// a press flag that is high on the edge the filtered state flips to pressed.
module key_debounce
   import key_press_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic Clock,
   input  logic Reset,
   input  logic key_n,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   key_st_e                st_q, st_d, level_c;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   press_c;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sync_q <= {SYNC_STAGES{~KEY_ACTIVE}};
         st_q   <= KEY_RELEASED;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         st_q   <= st_d;
         cnt_q  <= cnt_d;
      end
   end

   // Any sample matching the accepted state restarts the count.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], key_n};
      level_c = (sync_q[SYNC_STAGES-1] == KEY_ACTIVE) ? KEY_PRESSED : KEY_RELEASED;
      st_d    = st_q;
      cnt_d   = '0;
      press_c = 1'b0;
      if (level_c != st_q) begin
         if (cnt_q == CNT_MAX) begin
            st_d    = level_c;
            press_c = (level_c == KEY_PRESSED);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign press = press_c;

endmodule

// File: rtl/key_press_conditioner.sv
// Two-channel key conditioner: debounced L/R press pulses with tie arbitration
// and enable gating, all from registered outputs.
module key_press_conditioner
   import key_press_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic Clock,
   input  logic Reset,
   input  logic keyL_n,
   input  logic keyR_n,
   input  logic en,
   output logic L,
   output logic R,
   output logic tie
);

   logic       press_l, press_r;
   press_out_t out_q, out_d;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb_l (
      .Clock (Clock),
      .Reset (Reset),
      .key_n (keyL_n),
      .press (press_l)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_deb_r (
      .Clock (Clock),
      .Reset (Reset),
      .key_n (keyR_n),
      .press (press_r)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   always_comb begin
      out_d = '0;
      out_d = arbitrate(en, press_l, press_r);
   end

   assign L   = out_q.left;
   assign R   = out_q.right;
   assign tie = out_q.tie;

endmodule

// File: tb/tb_key_press_conditioner.sv
// Directed and randomised checks of key_press_conditioner against a sliding-window
// model of the debounce rule kept over the full per-edge input history.
module tb_key_press_conditioner;

   localparam int unsigned D    = 4;
   localparam int          MAXE = 8192;

   logic Clock = 1'b0;
   logic Reset, keyL_n, keyR_n, en;
   logic L, R, tie;

   int checks   = 0;
   int failures = 0;

   key_press_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .keyL_n (keyL_n),
      .keyR_n (keyR_n),
      .en     (en),
      .L      (L),
      .R      (R),
      .tie    (tie)
   );

   always #5 Clock = ~Clock;

   // Model: raw pressed level recorded per edge; debounced state flips when the
   // last D synchronised levels (raw from two edges earlier) all disagree with it.
   bit       raw_p [2][MAXE];
   bit       st    [2];
   int       last_evt [2];
   int       nxt  = 0;
   int       base = 0;
   bit [2:0] exp_out = 3'b000;

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s t=%0t observed{tie,R,L}=%b expected=%b", tag, $time, obs, expv);
      end
   endtask

   task automatic model_reset();
      base        = nxt;
      last_evt[0] = nxt - 1;
      last_evt[1] = nxt - 1;
      st[0]       = 1'b0;
      st[1]       = 1'b0;
      exp_out     = 3'b000;
   endtask

   task automatic model_edge();
      bit p [2];
      bit all_differ;
      bit lv;
      int n;
      int m;
      n = nxt;
      if (n < MAXE) begin
         raw_p[0][n] = (keyL_n == 1'b0);
         raw_p[1][n] = (keyR_n == 1'b0);
      end
      for (int c = 0; c < 2; c++) begin
         p[c] = 1'b0;
         if (n - last_evt[c] >= int'(D)) begin
            all_differ = 1'b1;
            for (int k = 0; k < int'(D); k++) begin
               m  = n - k - 2;
               lv = (m >= base && m < MAXE) ? raw_p[c][m] : 1'b0;
               if (lv == st[c]) all_differ = 1'b0;
            end
            if (all_differ) begin
               st[c]       = ~st[c];
               last_evt[c] = n;
               p[c]        = st[c];
            end
         end
      end
      exp_out = {en & p[0] & p[1], en & p[1] & ~p[0], en & p[0] & ~p[1]};
      nxt++;
   endtask

   // One clock: update model at the edge, compare just after, return at negedge.
   task automatic tick();
      @(posedge Clock);
      if (Reset) begin
         nxt++;
         model_reset();
      end else begin
         model_edge();
      end
      #1;
      check("model", {tie, R, L}, exp_out);
      @(negedge Clock);
   endtask

   task automatic settle(input int n);
      keyL_n = 1'b1;
      keyR_n = 1'b1;
      for (int i = 0; i < n; i++) tick();
   endtask

   int holdL, holdR;

   initial begin
      Reset  = 1'b0;
      keyL_n = 1'b1;
      keyR_n = 1'b1;
      en     = 1'b1;
      #2 Reset = 1'b1;
      model_reset();
      #1 check("reset_state", {tie, R, L}, 3'b000);
      @(negedge Clock);
      tick();
      tick();
      Reset = 1'b0;

      // Test 1: reset mid-cycle with keys idle
      settle(3);
      Reset = 1'b1;
      model_reset();
      #1 check("t1_async", {tie, R, L}, 3'b000);
      tick();
      Reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t1_idle", {tie, R, L}, 3'b000);
      end

      // Test 2: clean left press held 20 cycles
      keyL_n = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("t2_clean", {tie, R, L}, (i == 5) ? 3'b001 : 3'b000);
      end
      settle(8);

      // Test 3: bounce then steady low; four pressed samples end at raw index 10
      for (int i = 0; i < 20; i++) begin
         keyL_n = (i == 2 || i == 6) ? 1'b1 : 1'b0;
         tick();
         check("t3_bounce", {tie, R, L}, (i == 12) ? 3'b001 : 3'b000);
      end
      settle(8);

      // Test 4: simultaneous press
      keyL_n = 1'b0;
      keyR_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("t4_tie", {tie, R, L}, (i == 5) ? 3'b100 : 3'b000);
      end
      settle(8);

      // Test 5: staggered press, R first
      for (int i = 0; i < 14; i++) begin
         keyR_n = 1'b0;
         keyL_n = (i >= 3) ? 1'b0 : 1'b1;
         tick();
         check("t5_stagger", {tie, R, L},
               (i == 5) ? 3'b010 : ((i == 8) ? 3'b001 : 3'b000));
      end
      settle(8);

      // Test 6: press lost while disabled, no pulse on enable, fresh press pulses
      en     = 1'b0;
      keyL_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t6_gated", {tie, R, L}, 3'b000);
      end
      en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t6_held_en", {tie, R, L}, 3'b000);
      end
      keyL_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("t6_release", {tie, R, L}, 3'b000);
      end
      keyL_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("t6_repress", {tie, R, L}, (i == 5) ? 3'b001 : 3'b000);
      end
      settle(8);

      // Test 7: reset two edges into a press, key still held afterwards
      keyL_n = 1'b0;
      tick();
      tick();
      Reset = 1'b1;
      model_reset();
      #1 check("t7_async", {tie, R, L}, 3'b000);
      tick();
      tick();
      Reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("t7_after_rst", {tie, R, L}, (i == 5) ? 3'b001 : 3'b000);
      end
      settle(8);

      // Reset landing while a pulse is high clears it without waiting for a clock
      keyR_n = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      @(posedge Clock);
      model_edge();
      #1 check("pulse_live", {tie, R, L}, 3'b010);
      #1 Reset = 1'b1;
      model_reset();
      #1 check("pulse_async_clr", {tie, R, L}, 3'b000);
      @(negedge Clock);
      keyR_n = 1'b1;
      tick();
      Reset = 1'b0;
      settle(8);

      // Randomised bouncing keys, enable toggling and occasional resets
      holdL = 0;
      holdR = 0;
      for (int i = 0; i < 2000; i++) begin
         if (holdL == 0) begin
            keyL_n = 1'($urandom_range(0, 1));
            holdL  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2))
                                                 : int'($urandom_range(3, 14));
            if ($urandom_range(0, 3) == 0) begin
               keyR_n = keyL_n;
               holdR  = holdL;
            end
         end
         if (holdR == 0) begin
            keyR_n = 1'($urandom_range(0, 1));
            holdR  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2))
                                                 : int'($urandom_range(3, 14));
         end
         holdL--;
         holdR--;
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 249) == 0) begin
            Reset = 1'b1;
            model_reset();
            #1 check("rand_async", {tie, R, L}, 3'b000);
            tick();
            Reset = 1'b0;
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_press_conditioner.md
Name: key_press_conditioner

Overview:
Two-channel front end for the tug-of-war playfield. It turns the raw, active-low, bouncing KEY inputs into clean one-cycle L and R press pulses for the light chain. Each channel has a synchroniser, a debounce filter and rising-press detection. Simultaneous presses are arbitrated, and pulse generation can be gated off (for example when the game is over).

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a level change (must be >= 2).
CNT_W, $clog2(DEBOUNCE_CYCLES), width of each debounce counter.

Ports:
Clock  input  1  system clock; all state updates on rising edge.
Reset  input  1  asynchronous, active-high; clears all state immediately.
keyL_n  input  1  raw left key, active-low, asynchronous, may bounce.
keyR_n  input  1  raw right key, active-low, asynchronous, may bounce.
en  input  1  pulse enable; 0 suppresses L/R/tie, tracking continues.
L  output  1  one-cycle pulse per accepted left press.
R  output  1  one-cycle pulse per accepted right press.
tie  output  1  one-cycle pulse when both presses are accepted on the same edge.

Behaviour:
- Clocking and reset: one clock (Clock). Reset is asynchronous and active-high.
  - While Reset is high: sync flops = 1 (released), debounced state = 0 (released), counters = 0, L = R = tie = 0.
- Synchroniser: 2 flops per channel. The pressed level is the inverse of the second flop.
- Debounce, per channel; state st (1 = pressed) and counter cnt:
  - Synced level == st: cnt <= 0.
  - Synced level != st and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - Synced level != st and cnt == DEBOUNCE_CYCLES-1: st <= synced level, cnt <= 0.
  - Any glitch back to st before the threshold restarts the count from 0.
- Press event: asserted on the edge where st flips 0->1. Release (1->0) generates nothing.
- Output register (updated on the same edge as the flip):
  - pL = press event left, pR = press event right.
  - L <= en & pL & ~pR.
  - R <= en & pR & ~pL.
  - tie <= en & pL & pR.
  - Outputs are mutually exclusive and high for exactly one cycle.
- Latency: a key low at sampling edge k, held steady, gives its pulse high after edge k+1+DEBOUNCE_CYCLES. With the default, that is 5 edges after first sampling. No combinational path from inputs to outputs.
- Hold: a held key produces no repeat pulses. A new pulse requires a debounced release followed by a debounced press.
- en: sampled in the same edge as the output register.
  - A press accepted while en = 0 is lost; it is not queued.
  - Raising en while a key is held produces no pulse.
- Reset mid-operation: all state clears asynchronously and partial debounce counts are discarded. A key held through reset deassertion counts as a fresh press and pulses once after the full latency.
- Presses on the two channels one or more edges apart are independent: two separate pulses, no tie.

Decomposition:
- Shared game package: KEY_ACTIVE = 1'b0 (raw key pressed level) and DEFAULT_DEBOUNCE = 4.
- One sub-module, key_debounce, instantiated twice:
  - Contents: synchroniser, counter, st register and press-event output.
  - Ports: Clock, Reset, key_n, press.
- The top holds arbitration, en gating and the output registers.

Test Plan:
1. Reset: assert Reset mid-cycle with keys idle -> L = R = tie = 0 immediately (asynchronous). They stay 0 for 10 cycles after release.
2. Clean left press: keyL_n low at edge 0, held 20 cycles -> L = 1 exactly after edge 5 for one cycle. R = tie = 0 throughout. No second pulse while held.
3. Bounce: keyL_n pattern low,low,high,low,low,low,high,low... then steady low -> no pulse until the synced level is low for 4 consecutive samples. Then exactly one L pulse.
4. Simultaneous press: keyL_n and keyR_n fall on the same edge -> tie pulses once. L = R = 0.
5. Staggered press: keyR_n low at edge 0, keyL_n low at edge 3 -> R pulse after edge 5, L pulse after edge 8, tie = 0.
6. Enable gating: en = 0 during a left press, then en = 1 while held -> no pulse. Release for more than 6 cycles, press again with en = 1 -> one L pulse.
7. Reset during debounce: Reset asserted two edges into a press -> state clears. With the key still held after release, L pulses after the full 5-edge latency.
